// File: rtl/ghost_mode_pkg.sv
// rtl/ghost_mode_pkg.sv - shared types, tick width and phase schedule lookup for the ghost mode sequencer
package ghost_mode_pkg;

  localparam int TICK_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SCHED,
    ST_FRIGHT
  } gm_state_e;

  typedef struct packed {
    logic [TICK_W-1:0] dur;
    logic              scatter;
  } phase_entry_t;

  // Phase 7 returns a zero duration so its timer never reaches the expiry count.
  function automatic phase_entry_t phase_lookup(
    input logic [2:0]        ph,
    input logic [TICK_W-1:0] scatter_long,
    input logic [TICK_W-1:0] scatter_short,
    input logic [TICK_W-1:0] chase
  );
    phase_entry_t e;
    case (ph)
      3'd0, 3'd2:       e = '{dur: scatter_long,  scatter: 1'b1};
      3'd4, 3'd6:       e = '{dur: scatter_short, scatter: 1'b1};
      3'd1, 3'd3, 3'd5: e = '{dur: chase,         scatter: 1'b0};
      default:          e = '{dur: {TICK_W{1'b0}}, scatter: 1'b0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mode_phase_timer.sv
// rtl/mode_phase_timer.sv - frame-tick down-counter with load, hold and expiry strobe
module mode_phase_timer
  import ghost_mode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              hold,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  output logic [TICK_W-1:0] count_next,
  output logic              expire
);

  logic [TICK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && !hold && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the registered count so the owner can act on the same edge the tick is sampled.
  assign expire     = (count_q == TICK_W'(1)) & tick & ~hold;
  assign count_next = count_d;

endmodule

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - scatter/chase schedule with frightened overlay; FRIGHT_FLASH_EN enables frightFlash
module ghost_mode_scheduler
  import ghost_mode_pkg::*;
#(
  parameter int START_DELAY_T   = 300,
  parameter int SCATTER_LONG_T  = 420,
  parameter int SCATTER_SHORT_T = 300,
  parameter int CHASE_T         = 1200,
  parameter int FRIGHT_T        = 360,
  parameter int FLASH_T         = 120
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       power_pellet,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       frightFlash,
  output logic [2:0] phase,
  output logic       reverse_pulse
);

  localparam logic FRIGHT_EN = (FRIGHT_T != 0);

  gm_state_e         state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic              scatter_q, scatter_d;
  logic              chase_q, chase_d;
  logic              fright_q, fright_d;
  logic              flash_q, flash_d;
  logic              rev_q, rev_d;

  logic              pt_load, pt_hold, pt_expire;
  logic [TICK_W-1:0] pt_val, unused_pt_next;
  logic              ft_load, ft_hold, ft_expire;
  logic [TICK_W-1:0] ft_next;
  phase_entry_t      nxt_entry;

  // The schedule freezes while frightened; the fright timer only runs in FRIGHT.
  assign pt_hold = pause | (state_q == ST_FRIGHT) | (state_q == ST_IDLE);
  assign ft_hold = pause | (state_q != ST_FRIGHT);

  assign nxt_entry = phase_lookup(phase_q + 3'd1, TICK_W'(SCATTER_LONG_T),
                                  TICK_W'(SCATTER_SHORT_T), TICK_W'(CHASE_T));

  mode_phase_timer u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .tick       (frame_tick),
    .hold       (pt_hold),
    .load       (pt_load),
    .load_val   (pt_val),
    .count_next (unused_pt_next),
    .expire     (pt_expire)
  );

  mode_phase_timer u_fright_timer (
    .clk        (clk),
    .rst        (rst),
    .tick       (frame_tick),
    .hold       (ft_hold),
    .load       (ft_load),
    .load_val   (TICK_W'(FRIGHT_T)),
    .count_next (ft_next),
    .expire     (ft_expire)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    scatter_d = scatter_q;
    chase_d   = chase_q;
    rev_d     = 1'b0;
    pt_load   = 1'b0;
    pt_val    = '0;
    ft_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DELAY;
          pt_load = 1'b1;
          pt_val  = TICK_W'(START_DELAY_T);
        end
      end
      ST_DELAY: begin
        if (pt_expire) begin
          state_d   = ST_SCHED;
          phase_d   = 3'd0;
          scatter_d = 1'b1;
          chase_d   = 1'b0;
          pt_load   = 1'b1;
          pt_val    = TICK_W'(SCATTER_LONG_T);
        end
      end
      ST_SCHED: begin
        // Phase advance and pellet entry may coincide; both share one reverse pulse.
        if (pt_expire && (phase_q != 3'd7)) begin
          phase_d   = phase_q + 3'd1;
          scatter_d = nxt_entry.scatter;
          chase_d   = ~nxt_entry.scatter;
          pt_load   = 1'b1;
          pt_val    = nxt_entry.dur;
          rev_d     = 1'b1;
        end
        if (power_pellet && FRIGHT_EN) begin
          state_d = ST_FRIGHT;
          ft_load = 1'b1;
          rev_d   = 1'b1;
        end
      end
      ST_FRIGHT: begin
        if (power_pellet) begin
          ft_load = 1'b1;
        end else if (ft_expire) begin
          state_d = ST_SCHED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fright_d = (state_d == ST_FRIGHT);
`ifdef FRIGHT_FLASH_EN
    flash_d = fright_d && (ft_next <= TICK_W'(FLASH_T));
`else
    flash_d = 1'b0;
`endif
  end

`ifndef FRIGHT_FLASH_EN
  logic unused_flash_cfg;
  assign unused_flash_cfg = ^{ft_next, FLASH_T[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      scatter_q <= 1'b0;
      chase_q   <= 1'b0;
      fright_q  <= 1'b0;
      flash_q   <= 1'b0;
      rev_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      scatter_q <= scatter_d;
      chase_q   <= chase_d;
      fright_q  <= fright_d;
      flash_q   <= flash_d;
      rev_q     <= rev_d;
    end
  end

  assign isScatter     = scatter_q;
  assign isChase       = chase_q;
  assign isFrightened  = fright_q;
  assign frightFlash   = flash_q;
  assign phase         = phase_q;
  assign reverse_pulse = rev_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb/tb_ghost_mode_scheduler.sv - directed self-checking bench for ghost_mode_scheduler
module tb_ghost_mode_scheduler;

`ifdef FRIGHT_FLASH_EN
  localparam logic FLASH_EN = 1'b1;
`else
  localparam logic FLASH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, frame_tick, start, pause, power_pellet;
  logic       isScatter, isChase, isFrightened, frightFlash, reverse_pulse;
  logic [2:0] phase;
  int         vectors = 0;
  int         miscompares = 0;
  int         rev_total;
  int         exp_ph;
  logic       exp_rev;
  int         bounds [8] = '{5, 9, 19, 23, 33, 36, 46, 49};

  always #5 clk = ~clk;

  ghost_mode_scheduler #(
    .START_DELAY_T   (5),
    .SCATTER_LONG_T  (4),
    .SCATTER_SHORT_T (3),
    .CHASE_T         (10),
    .FRIGHT_T        (6),
    .FLASH_T         (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .pause         (pause),
    .power_pellet  (power_pellet),
    .isScatter     (isScatter),
    .isChase       (isChase),
    .isFrightened  (isFrightened),
    .frightFlash   (frightFlash),
    .phase         (phase),
    .reverse_pulse (reverse_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mode(input string tag, input int ph, input logic sc, input logic ch,
                          input logic fr, input logic rv);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".isScatter"}, 32'(isScatter), 32'(sc));
    chk({tag, ".isChase"}, 32'(isChase), 32'(ch));
    chk({tag, ".isFrightened"}, 32'(isFrightened), 32'(fr));
    chk({tag, ".reverse_pulse"}, 32'(reverse_pulse), 32'(rv));
  endtask

  task automatic cyc(input logic ft, input logic pp, input logic st);
    @(negedge clk);
    frame_tick   = ft;
    power_pellet = pp;
    start        = st;
    @(posedge clk);
    #1;
    frame_tick   = 1'b0;
    power_pellet = 1'b0;
    start        = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; power_pellet = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_mode("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.frightFlash", 32'(frightFlash), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: start delay then first phase change
    cyc(1'b0, 1'b1, 1'b0);
    chk_mode("idle_pellet", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    ticks(2);
    cyc(1'b0, 1'b1, 1'b0);
    chk_mode("delay_pellet", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk_mode("delay_t4", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk_mode("t1_phase0", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3);
    chk_mode("t1_phase0_end", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk_mode("t1_phase1", 1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t1_rev_drop", 32'(reverse_pulse), 32'd0);

    // 2: full schedule, tick n counted from start
    rev_total = 1;
    for (int n = 10; n <= 63; n++) begin
      ticks(1);
      exp_ph  = -1;
      exp_rev = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (bounds[k] <= n) exp_ph++;
        if (k > 0 && bounds[k] == n) exp_rev = 1'b1;
      end
      chk($sformatf("t2_n%0d", n), 32'(phase), 32'(exp_ph));
      chk($sformatf("t2_rev_n%0d", n), 32'(reverse_pulse), 32'(exp_rev));
      chk($sformatf("t2_chase_n%0d", n), 32'(isChase), 32'(exp_ph % 2));
      rev_total += int'(reverse_pulse);
    end
    for (int n = 0; n < 15; n++) begin
      ticks(1);
      rev_total += int'(reverse_pulse);
    end
    chk("t2_rev_total", 32'(rev_total), 32'd7);
    chk_mode("t2_phase7_hold", 7, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3: frightened overlay pauses phase 1
    do_reset();
    cyc(1'b0, 1'b0, 1'b1);
    ticks(9);
    chk_mode("t3_phase1", 1, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(2);
    cyc(1'b0, 1'b1, 1'b0);
    chk_mode("t3_fright_on", 1, 1'b0, 1'b1, 1'b1, 1'b1);
    ticks(5);
    chk_mode("t3_fright_t5", 1, 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(1);
    chk_mode("t3_fright_off", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    chk_mode("t3_resume_t7", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_mode("t3_phase2", 2, 1'b1, 1'b0, 1'b0, 1'b1);

    // 4: reload at fright tick 4, flash on final two ticks
    cyc(1'b0, 1'b1, 1'b0);
    chk_mode("t4_fright_on", 2, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t4_flash_on", 32'(frightFlash), 32'd0);
    ticks(3);
    cyc(1'b1, 1'b1, 1'b0);
    chk_mode("t4_reload", 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_flash_reload", 32'(frightFlash), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      ticks(1);
      chk_mode($sformatf("t4_k%0d", k), 2, 1'b1, 1'b0, 32'(k < 6), 1'b0);
      chk($sformatf("t4_flash_k%0d", k), 32'(frightFlash),
          32'(FLASH_EN && (k == 4 || k == 5)));
    end
    ticks(3);
    chk_mode("t4_phase2_held", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk_mode("t4_phase3", 3, 1'b0, 1'b1, 1'b0, 1'b1);

    // 5: pellet on the same edge as phase 0 expiry
    do_reset();
    cyc(1'b0, 1'b0, 1'b1);
    ticks(5);
    chk_mode("t5_phase0", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b1, 1'b1, 1'b0);
    chk_mode("t5_both", 1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk_mode("t5_single_pulse", 1, 1'b0, 1'b1, 1'b1, 1'b0);

    // 6: pause freezes everything, async reset mid-fright
    ticks(6);
    chk_mode("t6_fright_off", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    pause = 1'b1;
    rev_total = 0;
    for (int n = 0; n < 20; n++) begin
      ticks(1);
      rev_total += int'(reverse_pulse);
    end
    chk("t6_pause_rev", 32'(rev_total), 32'd0);
    chk_mode("t6_paused", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_mode("t6_pause_pellet", 1, 1'b0, 1'b1, 1'b1, 1'b1);
    ticks(10);
    chk_mode("t6_pause_fright", 1, 1'b0, 1'b1, 1'b1, 1'b0);
    pause = 1'b0;
    ticks(3);
    chk_mode("t6_fright_run", 1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_mode("t6_async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_async_rst.frightFlash", 32'(frightFlash), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    ticks(4);
    chk_mode("t6_restart_delay", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk_mode("t6_restart_phase0", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
